// File: rtl/mux_sched_pkg.sv
// Shared scheduler types: FSM state, requester indices, round-robin pick helper.
package mux_sched_pkg;
  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  localparam logic [1:0] REQ_A = 2'd0;
  localparam logic [1:0] REQ_B = 2'd1;
  localparam logic [1:0] REQ_C = 2'd2;
  localparam logic [1:0] REQ_D = 2'd3;

  // First set bit searching last+1, last+2, last+3, last (mod 4).
  // The loop runs from the far end so the nearest hit wins.
  function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] last);
    logic [1:0] idx;
    rr_pick = last;
    for (int k = 4; k >= 1; k--) begin
      idx = last + 2'(k);
      if (req[idx]) rr_pick = idx;
    end
  endfunction
endpackage

// File: rtl/mux_rr_scheduler_mux4.sv
// Plain 4:1 data selector used as the scheduler's datapath mux.
module mux_rr_scheduler_mux4 #(
  parameter int W = 4
) (
  input  logic [1:0]   sel,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  input  logic [W-1:0] d,
  output logic [W-1:0] y
);
  always_comb begin
    unique case (sel)
      2'd0:    y = a;
      2'd1:    y = b;
      2'd2:    y = c;
      default: y = d;
    endcase
  end
endmodule

// File: rtl/mux_rr_scheduler.sv
// Round-robin 4-requester scheduler with per-grant hold limit and a
// single-entry valid/ready output register.
module mux_rr_scheduler
  import mux_sched_pkg::*;
#(
  parameter int DATA_W   = 4,
  parameter int MAX_HOLD = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        req,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] c,
  input  logic [DATA_W-1:0] d,
  input  logic              ready,
  output logic [3:0]        gnt,
  output logic [1:0]        sel,
  output logic [DATA_W-1:0] y,
  output logic              valid
);
  localparam logic [3:0] HOLD = 4'(MAX_HOLD);

  state_t            state;
  logic [1:0]        last;
  logic [3:0]        cnt;
  logic [DATA_W-1:0] mux_y;
  logic [1:0]        pick;
  logic              slot_free;

  assign slot_free = !valid || ready;
  assign pick      = rr_pick(req, last);

  mux_rr_scheduler_mux4 #(.W(DATA_W)) u_mux (
    .sel(sel), .a(a), .b(b), .c(c), .d(d), .y(mux_y)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      gnt   <= 4'b0;
      sel   <= REQ_A;
      y     <= '0;
      valid <= 1'b0;
      cnt   <= 4'd0;
      last  <= REQ_D;
    end else begin
      case (state)
        IDLE: begin
          if (valid && ready) valid <= 1'b0;
          if (|req) begin
            sel   <= pick;
            gnt   <= 4'b1 << pick;
            cnt   <= 4'd0;
            state <= GRANT;
          end
        end
        GRANT: begin
          if (req[sel]) begin
            // A stalled slot holds y/valid/cnt untouched.
            if (slot_free) begin
              y     <= mux_y;
              valid <= 1'b1;
              cnt   <= cnt + 4'd1;
              if (4'(cnt + 4'd1) == HOLD) begin
                state <= IDLE;
                gnt   <= 4'b0;
                last  <= sel;
              end
            end
          end else begin
            if (valid && ready) valid <= 1'b0;
            state <= IDLE;
            gnt   <= 4'b0;
            last  <= sel;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/mux_rr_scheduler.md
MUX_RR_SCHEDULER -- requirements
Module: mux_rr_scheduler

Interface
REQ-001 Parameter DATA_W, default 4, width of each requester data word and of y.
REQ-002 Parameter MAX_HOLD, default 4, maximum words one requester may transfer per grant (legal range 1..15).
REQ-003 The clock and reset SHALL be a single clock, clk, and a synchronous active-high reset, rst.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 req  input  4  request per requester; bit0=a, bit1=b, bit2=c, bit3=d.
REQ-007 a, b, c, d  input  DATA_W each  requester data words.
REQ-008 gnt  output  4  one-hot grant, or all zero when no grant is held.
REQ-009 sel  output  2  registered mux select: 0=a, 1=b, 2=c, 3=d.
REQ-010 y  output  DATA_W  registered output word.
REQ-011 valid  output  1  y holds an unconsumed word.
REQ-012 ready  input  1  downstream accepts y when valid&&ready at a rising edge.

Function
REQ-013 The FSM SHALL have two states, IDLE (gnt=0) and GRANT (gnt=1<<sel).
REQ-014 In IDLE, if req!=0, the block SHALL pick the first set bit searching last+1, last+2, last+3, last (mod 4), load sel, set gnt, clear cnt and enter GRANT on the next edge (1-cycle grant latency).
REQ-015 In IDLE with req==0, the block SHALL stay in IDLE and leave sel, last and cnt unchanged.
REQ-016 Define slot_free = !valid || ready.
REQ-017 In GRANT with req[sel]=1 and slot_free, the block SHALL load y with the input chosen by sel, set valid=1 and increment cnt (4-bit).
REQ-018 In GRANT with req[sel]=1 and !slot_free, the block SHALL hold y, valid and cnt (backpressure stall, no data loss).
REQ-019 When valid&&ready and no new word is loaded that cycle, the block SHALL clear valid.
REQ-020 The block SHALL release from GRANT to IDLE on the edge where req[sel]=0 (no word loaded), or where a load makes cnt reach MAX_HOLD.
REQ-021 On release the block SHALL set gnt=0 and last=sel; y and valid SHALL keep draining independently.
REQ-022 A requester releases at most MAX_HOLD words per grant; continuous requesters SHALL be served a,b,c,d,a,... with no starvation.
REQ-023 A new grant MAY be issued while the previous word is still valid; its first load waits for slot_free.
REQ-024 Changes on a, b, c or d while valid=1 SHALL NOT alter y.
REQ-025 The IDLE-to-GRANT transition SHALL take exactly one cycle, giving one idle cycle between consecutive grants.

Reset
REQ-026 When rst=1 at an edge, the block SHALL set state=IDLE, gnt=0, sel=0, y=0, valid=0, cnt=0 and last=3 (requester a has top priority first).
REQ-027 Reset SHALL override all other activity, including mid-grant and with valid=1; the pending word is discarded.

Structure
REQ-028 A shared package mux_sched_pkg SHALL hold the state enum (IDLE, GRANT) and the requester index constants.
REQ-029 The existing 4:1 mux SHALL be instantiated once as the data selector, driven by sel; no other sub-modules.

Verification
REQ-030 Reset: rst=1 for 2 cycles with req=4'hF -> gnt=0, sel=0, y=0, valid=0; after release, gnt=4'b0001 one cycle later.
REQ-031 Hold limit: req=4'b0001, a=4'h5, ready=1 -> exactly 4 words of 5, then gnt=0 for 1 cycle, then gnt=4'b0001 again.
REQ-032 Round robin: req=4'hF, ready=1, a/b/c/d=1/2/3/4 -> y sequence 1x4, 2x4, 3x4, 4x4, 1x4.
REQ-033 Backpressure: granted b=4'h9, ready=0 for 5 cycles -> valid=1, y=9, cnt=1 held; ready=1 -> transfers resume with no lost or duplicated word.
REQ-034 Early drop: req=4'b0100 dropped after 2 words -> release with last=2; next req=4'b0101 grants a (bit0) before c.
REQ-035 Mid-grant reset: rst pulsed with valid=1 during a c grant -> next cycle valid=0, gnt=0; the following grant starts from a.
